// File: rtl/route_req_gen.sv
// Per-input routing-request generator: decodes head-flit destinations into one-hot
// output-port requests, holds them through grant and packet transfer, flags protocol errors.
module route_req_gen #(
  parameter int unsigned NIN   = 2,
  parameter int unsigned NPORT = 4,
  parameter int unsigned PKTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NIN*PKTW-1:0]   in_flit,
  input  logic [NIN-1:0]        in_valid,
  input  logic [NIN-1:0]        in_ready,
  input  logic [NIN-1:0]        grant,
  input  logic [NIN-1:0]        err_clr,
  output logic [NIN*NPORT-1:0]  req,
  output logic [NIN-1:0]        owned,
  output logic [NIN-1:0]        err
);

  localparam int unsigned DSTW = (NPORT > 2) ? $clog2(NPORT) : 1;

  localparam logic [1:0] FlowBody     = 2'b00;
  localparam logic [1:0] FlowHead     = 2'b01;
  localparam logic [1:0] FlowTail     = 2'b10;
  localparam logic [1:0] FlowHeadTail = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StGnt, StXfer} state_e;

  for (genvar gi = 0; gi < NIN; gi++) begin : g_ch
    logic [1:0]       w_flow;
    logic [DSTW-1:0]  w_dest;
    logic             w_is_head;
    logic             w_dest_ok;
    logic             w_xfer;
    logic             w_err_set;
    logic [NPORT-1:0] w_onehot;

    state_e           r_state;
    logic [NPORT-1:0] r_req;
    logic             r_owned;
    logic             r_err;

    assign w_flow    = in_flit[gi*PKTW+PKTW-2 +: 2];
    assign w_dest    = in_flit[gi*PKTW +: DSTW];
    // HEAD and HEADTAIL both carry the low flow bit.
    assign w_is_head = w_flow[0];
    assign w_dest_ok = 32'(w_dest) < NPORT;
    assign w_onehot  = NPORT'(1) << w_dest;
    assign w_xfer    = in_valid[gi] & in_ready[gi] & r_owned;

    always_comb begin
      w_err_set = 1'b0;
      unique case (r_state)
        StIdle:  w_err_set = in_valid[gi] & ~(w_is_head & w_dest_ok);
        StGnt:   w_err_set = w_xfer & ~w_is_head;
        StXfer:  w_err_set = w_xfer & w_is_head;
        default: w_err_set = 1'b0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= StIdle;
        r_req   <= '0;
        r_owned <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (w_err_set) begin
          r_err <= 1'b1;
        end else if (err_clr[gi]) begin
          r_err <= 1'b0;
        end

        case (r_state)
          StIdle: begin
            if (in_valid[gi] && w_is_head && w_dest_ok) begin
              r_req   <= w_onehot;
              r_state <= StReq;
            end
          end
          StReq: begin
            if (grant[gi]) begin
              r_owned <= 1'b1;
              r_state <= StGnt;
            end
          end
          StGnt: begin
            if (w_xfer) begin
              if (w_flow == FlowHead) begin
                r_state <= StXfer;
              end else begin
                r_state <= StIdle;
                r_req   <= '0;
                r_owned <= 1'b0;
              end
            end
          end
          StXfer: begin
            // Only BODY keeps the packet open; TAIL ends it, a head here is an error.
            if (w_xfer && (w_flow == FlowTail || w_flow == FlowHead ||
                           w_flow == FlowHeadTail)) begin
              r_state <= StIdle;
              r_req   <= '0;
              r_owned <= 1'b0;
            end
          end
          default: begin
            r_state <= StIdle;
            r_req   <= '0;
            r_owned <= 1'b0;
          end
        endcase
      end
    end

    assign req[gi*NPORT +: NPORT] = r_req;
    assign owned[gi]              = r_owned;
    assign err[gi]                = r_err;
  end

endmodule

// File: doc/route_req_gen.md
# route_req_gen

Parametrised per-input routing-request generator for the packet switch. Sits between the input flit buffers and the output-port arbiters. For each of NIN input channels it decodes the destination of a head flit into a one-hot output-port request, holds it through arbitration and packet transfer, and drops it after the tail flit is accepted. It also flags flow-control protocol violations per input.

## Interface
- NIN, 2, number of input channels
- NPORT, 4, number of output ports; 2..16
- PKTW, 16, flit width; flow field is bits [PKTW-1:PKTW-2]; destination field is bits [DSTW-1:0]
- DSTW (derived localparam), max(1, clog2(NPORT)), destination field width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- in_flit  in  NIN*PKTW  flit of input i at [i*PKTW +: PKTW]
- in_valid  in  NIN  flit of input i valid
- in_ready  in  NIN  crossbar accepts flit of input i this cycle
- grant  in  NIN  arbiter grants input i its requested port
- err_clr  in  NIN  pulse; clears err[i]
- req  out  NIN*NPORT  one-hot port request of input i at [i*NPORT +: NPORT]; registered
- owned  out  NIN  input i holds its output port (granted packet in flight); registered
- err  out  NIN  sticky protocol-error flag; registered

## Operation
- Flow encoding: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEADTAIL (single-flit packet).
- Transfer for input i: xfer = in_valid & in_ready & owned (registered owned).
- One independent FSM per input. States: IDLE, REQ, GNT, XFER.
- IDLE (req=0, owned=0):
  - in_valid with HEAD or HEADTAIL and dest < NPORT: latch dest; req = one-hot(dest); go to REQ.
  - in_valid with HEAD or HEADTAIL and dest >= NPORT: set err; stay in IDLE; req stays 0.
  - in_valid with BODY or TAIL: set err; stay in IDLE.
- REQ (req held): on grant go to GNT with owned=1. No flit is consumed. in_flit is not re-decoded.
- GNT (req and owned held): waiting for the head to transfer.
  - xfer of HEAD: go to XFER.
  - xfer of HEADTAIL: go to IDLE; req and owned clear.
  - xfer of BODY or TAIL: set err; go to IDLE; clear req and owned.
- XFER (req and owned held):
  - xfer of BODY: stay in XFER.
  - xfer of TAIL: go to IDLE; clear req and owned.
  - xfer of HEAD or HEADTAIL: set err; go to IDLE; clear req and owned.
- grant is ignored outside REQ. in_ready is ignored when owned=0.
- err: set has priority over err_clr in the same cycle. err_clr alone clears err. err has no effect on the FSM.

## Timing
- Reset values: all FSMs in IDLE; req=0, owned=0, err=0. Reset is asynchronous and takes effect mid-packet with no cleanup.
- Head valid in IDLE at edge k: req visible after edge k (1-cycle latency).
- grant high at edge k in REQ: owned high after edge k. The first xfer can occur in the cycle following edge k.
- Tail xfer at edge k: req and owned low after edge k. A next head presented after edge k gives req high after edge k+1, so there is 1 idle-req cycle between packets.
- in_valid or in_ready low: no state change in GNT/XFER. Req is held indefinitely.
- Channels are fully independent. Several inputs may request the same port simultaneously; arbitration is external.

## Test plan
- Reset: assert rst mid-stream with input 0 in XFER. Required: req=0, owned=0, err=0 immediately; all FSMs IDLE after release.
- NIN=2, NPORT=4, input 0 packet HEAD(dest 2), BODY, BODY, TAIL, with grant 2 cycles after req. Required: req[3:0]=4'b0100 one cycle after head; owned=1 after grant; 4 xfers; req=0 and owned=0 the cycle after the TAIL xfer.
- Input 1 HEADTAIL dest 3 while input 0 streams to port 3. Required: req[7:4]=4'b1000 concurrently with req[3:0]; after grant, one xfer returns input 1 to IDLE; input 0 unaffected.
- Stall: in_ready=0 for 5 cycles with TAIL valid in XFER. Required: req and owned held; cleared only the cycle after the in_ready=1 xfer.
- Errors: BODY valid on input 0 in IDLE gives err[0]=1 with req unchanged. A HEAD xfer in XFER gives err=1, IDLE, req=0. err_clr with no new error gives err=0. err_clr in the same cycle as a new error leaves err=1.
- NPORT=3, head with dest 3: err=1, req stays 3'b000, FSM stays IDLE; a following head with dest 1 gives req=3'b010.
